// File: rtl/microwave_timer_input_if.sv
// Keypad-entry bus: digit switches in, BCD display digits and key code out.
interface microwave_timer_input_if;
  logic [9:0] switches;
  logic [3:0] units_of_seconds;
  logic [3:0] tens_of_seconds;
  logic [3:0] units_of_minutes;
  logic [3:0] encoded;

  // Keypad / stimulus side
  modport master (
    output switches,
    input  units_of_seconds, tens_of_seconds, units_of_minutes, encoded
  );

  // Timer-input block side
  modport slave (
    input  switches,
    output units_of_seconds, tens_of_seconds, units_of_minutes, encoded
  );
endinterface

// File: rtl/microwave_timer_input.sv
// Microwave cook-time keypad front end: registered 10-to-4 priority encoder,
// key-press edge detection and a right-filling three-digit BCD M:SS register.

// 10-to-4 priority encoder; highest set index wins, 4'hF when idle/disabled.
module microwave_priority_enc (
  input  logic       i_en,
  input  logic [9:0] i_sw,
  output logic [3:0] o_code
);
  // Ascending scan so the last (highest) set bit overrides lower ones
  always_comb begin
    o_code = 4'hF;
    if (i_en) begin
      for (int i = 0; i < 10; i++) begin
        if (i_sw[i]) o_code = 4'(i);
      end
    end
  end
endmodule

// One BCD display digit; loads its shift input on a key event.
module microwave_digit_cell #(
  parameter int DIG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DIG_W-1:0] i_d,
  output logic [DIG_W-1:0] o_q
);
  logic [DIG_W-1:0] r_q;

  // Digit holds unless a key event shifts the display
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module microwave_timer_input (
  input  logic                          clk,
  input  logic                          rst,   // async, active low
  microwave_timer_input_if.slave        bus
);
  localparam int         NUM_DIGITS = 3;
  localparam int         DIG_W      = 4;
  localparam logic [3:0] CODE_NONE  = 4'hF;

  logic [3:0]                        w_code;
  logic [3:0]                        r_encoded;
  logic [3:0]                        r_prev_code;
  logic                              w_key_event;
  logic [NUM_DIGITS-1:0][DIG_W-1:0]  w_shift_in;
  logic [NUM_DIGITS-1:0][DIG_W-1:0]  w_digit;

  // Enable is tied high; the encoder is always active in this block
  microwave_priority_enc u_enc (
    .i_en   (1'b1),
    .i_sw   (bus.switches),
    .o_code (w_code)
  );

  // Register the key code and remember last cycle's code for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_encoded   <= CODE_NONE;
      r_prev_code <= CODE_NONE;
    end else begin
      r_encoded   <= w_code;
      r_prev_code <= r_encoded;
    end
  end

  // A new non-idle code is one key press; holding a key or releasing is not.
  // prev_code restarts at F after reset, so a key held through reset counts once.
  assign w_key_event = (r_encoded != CODE_NONE) && (r_encoded != r_prev_code);

  // Display fills from the right: new digit enters seconds-units and the
  // older digits move one place left, the minutes digit falling off the end
  assign w_shift_in[0] = r_encoded;

  genvar g;
  generate
    for (g = 1; g < NUM_DIGITS; g++) begin : g_chain
      assign w_shift_in[g] = w_digit[g-1];
    end

    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      microwave_digit_cell #(.DIG_W(DIG_W)) u_cell (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_key_event),
        .i_d    (w_shift_in[g]),
        .o_q    (w_digit[g])
      );
    end
  endgenerate

  // No clamping here: tens-of-seconds may read above 5, normalised downstream
  assign bus.units_of_seconds = w_digit[0];
  assign bus.tens_of_seconds  = w_digit[1];
  assign bus.units_of_minutes = w_digit[2];
  assign bus.encoded          = r_encoded;
endmodule

// File: tb/tb_microwave_timer_input.sv
// Bench for microwave_timer_input: directed entry sequence plus random keying
// against a decimal-number model of the last three entered digits.
module tb_microwave_timer_input;
  logic clk = 1'b0;
  logic rst = 1'b0;
  microwave_timer_input_if bus ();

  microwave_timer_input dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: code seen last edge, code before that, and the entered time as a
  // decimal number 0..999 (last three digits typed).
  int m_enc, m_prev, m_entry;

  function automatic int top_key(logic [9:0] sw);
    int r = 15;
    for (int i = 0; i < 10; i++) if (sw[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_enc = 15; m_prev = 15; m_entry = 0;
  endtask

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".enc"}, bus.encoded,          4'(m_enc));
    check({tag, ".us"},  bus.units_of_seconds, 4'(m_entry % 10));
    check({tag, ".ts"},  bus.tens_of_seconds,  4'((m_entry / 10) % 10));
    check({tag, ".um"},  bus.units_of_minutes, 4'(m_entry / 100));
  endtask

  task automatic check_disp(string tag, int m, int t, int u);
    check({tag, ".um"}, bus.units_of_minutes, 4'(m));
    check({tag, ".ts"}, bus.tens_of_seconds,  4'(t));
    check({tag, ".us"}, bus.units_of_seconds, 4'(u));
  endtask

  // One clock: drive keys (and keep reset released), then check model after edge
  task automatic step(string tag, logic [9:0] sw);
    @(negedge clk);
    bus.switches = sw;
    rst = 1'b1;
    @(posedge clk);
    #1;
    if (m_enc != 15 && m_enc != m_prev) m_entry = (m_entry * 10 + m_enc) % 1000;
    m_prev = m_enc;
    m_enc  = top_key(sw);
    check_all(tag);
  endtask

  task automatic hold(string tag, logic [9:0] sw, int n);
    for (int i = 0; i < n; i++) step(tag, sw);
  endtask

  initial begin
    bus.switches = '0;
    model_reset();

    // Reset held low
    repeat (10) @(posedge clk);
    #1;
    check_all("reset");
    hold("idle", 10'b0, 100);
    check_disp("idle_c", 0, 0, 0);

    // Entry sequence 8, 0, 7
    hold("key8", 10'b0100000000, 100);
    check("key8_c.enc", bus.encoded, 4'd8);
    check_disp("key8_c", 0, 0, 8);
    hold("key0", 10'b0000000001, 10);
    check_disp("key0_c", 0, 8, 0);
    hold("key7", 10'b0010000000, 10);
    check("key7_c.enc", bus.encoded, 4'd7);
    check_disp("key7_c", 8, 0, 7);

    // Async reset between edges, key 7 still held
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_disp("async_rst", 0, 0, 0);
    check("async_rst.enc", bus.encoded, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold");
    hold("rel7", 10'b0010000000, 20);
    check_disp("rel7_c", 0, 0, 7);

    // Priority: 9 beats 2 and 0
    hold("prio", 10'b1000000101, 10);
    check("prio_c.enc", bus.encoded, 4'd9);
    check_disp("prio_c", 0, 7, 9);

    // Release and repress 5
    hold("r_off", 10'b0, 3);
    hold("r_5a",  10'b0000100000, 3);
    hold("r_off", 10'b0, 3);
    hold("r_5b",  10'b0000100000, 50);
    check_disp("repress_c", 9, 5, 5);

    // Overflow: 1,2,3,4 moving key to key directly
    hold("ov1", 10'b0000000010, 3);
    hold("ov2", 10'b0000000100, 3);
    hold("ov3", 10'b0000001000, 3);
    hold("ov4", 10'b0000010000, 3);
    check_disp("ovf_c", 2, 3, 4);

    // Random keying: idle, single keys and chords with random hold times
    for (int b = 0; b < 300; b++) begin
      logic [9:0] sw;
      int mode;
      mode = $urandom_range(0, 3);
      if (mode == 0)      sw = '0;
      else if (mode == 3) sw = 10'($urandom);
      else                sw = 10'(1) << $urandom_range(0, 9);
      hold("rand", sw, $urandom_range(1, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/microwave_timer_input.md
# microwave_timer_input

Keypad-entry front end for the microwave cook-time setting. Ten one-hot-style digit switches go through a registered 10-to-4 priority encoder. Each new key press shifts one BCD digit into a three-digit M:SS display register, the way a microwave keypad fills the time from the right. The three BCD digits feed the countdown/control and display blocks downstream.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately; release is sampled on clk.
- switches  input  10  digit keys; switches[i] high = digit i pressed.
- units_of_seconds  output  4  BCD seconds-units digit (rightmost).
- tens_of_seconds  output  4  BCD seconds-tens digit.
- units_of_minutes  output  4  BCD minutes digit (leftmost).
- encoded  output  4  registered priority-encoder code: the current key, or 4'hF when no key is pressed.

## Operation
- Priority encoder:
  - Internal submodule with enable tied high.
  - Output = index of the highest set bit of switches (9 down to 0). Example: switches[9] beats every other bit.
  - If no bit is set, output 4'hF.
  - If enable is low, output 4'hF.
  - The output is registered and appears on `encoded`.
- Key-press detection:
  - prev_code register holds the previous cycle's `encoded`.
  - A key event occurs when `encoded` != 4'hF and `encoded` != prev_code.
  - Holding a key yields exactly one event.
  - Moving directly from one key to a different key (no release in between) yields a new event.
  - Releasing all keys (code F) yields no event.
  - Pressing the same key again after a release yields a new event.
- Digit shift on a key event with digit d:
  - units_of_minutes <= tens_of_seconds
  - tens_of_seconds <= units_of_seconds
  - units_of_seconds <= d
  - The old minutes digit is discarded.
- No range clamping. Each digit holds 0–9, and tens_of_seconds may exceed 5 (for example, 0:90 means 90 s). Normalisation is the downstream controller's job.
- Outside a key event, all three digits hold their values.
- Codes A–E never occur, because the encoder only produces 0–9 or F.

## Timing
- Reset (rst low, asynchronous):
  - units_of_seconds, tens_of_seconds and units_of_minutes = 0.
  - encoded = 4'hF; prev_code = 4'hF.
- Latency from a switches change:
  - Edge N: encoded updates.
  - Edge N+1: the digit shift occurs and prev_code updates.
  - Digit outputs therefore change 2 clock edges after the switches change is first sampled.
- Output stability: outputs change only on clk edges or on reset assertion.
- Reset mid-entry: digits clear at once. A key still held when rst rises produces one event, because prev_code restarts at F.
- Simultaneous keys: the highest index wins. If a higher key is added while a lower one is held, the code changes and a new event fires.

## Test plan
- Reset: hold rst low for 10 cycles with switches = 0 -> all digits 0 and encoded = F. Release rst and idle 100 cycles -> digits stay 0:00.
- Entry sequence: switches = 10'b0100000000 (digit 8) held 100 cycles -> encoded = 8 and display 0:08, with exactly one shift. Then switches = 10'b0000000001 -> encoded = 0, display 0:80. Then switches = 10'b0010000000 -> encoded = 7, display 8:07.
- Priority: switches = 10'b1000000101 -> encoded = 9, one shift of 9.
- Release and repress: press 5, release to 0, press 5 -> two events, units = 5 and tens = 5. Holding 5 for 50 cycles adds no further shifts.
- Overflow: enter 1, 2, 3, 4 -> display 2:34; the first digit is dropped.
- Async reset mid-operation: from 8:07, drive rst low between clock edges -> digits 0 immediately, before the next edge. Release rst with key 7 held -> exactly one shift, display 0:07.
